// File: rtl/ctrl_pkg.sv
// Shared encodings and default widths for the datapath control sequencer.
package ctrl_pkg;

    localparam int REG_AW = 5;
    localparam int ALUC_W = 5;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        OP_ALU   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    // Codes 5..7 are unused; the sequencer treats them as illegal and
    // falls back to IDLE with all strobes low.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_EXEC = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4
    } state_e;

endpackage

// File: rtl/ctrl_out_decode.sv
// Strobe decode: regw/memw/memr as a pure function of state and latched op.
// Every strobe is low in IDLE, READ, EXEC and in any illegal state code, so
// the three strobes can never be high together.
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  state_e state,
    input  op_e    op,
    output logic   regw,
    output logic   memw,
    output logic   memr
);

    // Memory strobes only in MEM (read for LOAD, write for STORE); register
    // write only in WB, which only ALU and LOAD commands reach.
    always_comb begin
        regw = 1'b0;
        memw = 1'b0;
        memr = 1'b0;
        case (state)
            ST_MEM: begin
                memr = (op == OP_LOAD);
                memw = (op == OP_STORE);
            end
            ST_WB:   regw = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/datapath_ctrl_seq.sv
// Multi-cycle control sequencer for the register-file/ALU/memory datapath.
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high exactly while the FSM is IDLE,
// so cmd_valid is ignored while busy and the command fields are latched at
// the transfer edge. All datapath controls come from registers, so they
// only change just after a rising clk edge.
module datapath_ctrl_seq #(
    parameter int REG_AW = ctrl_pkg::REG_AW,
    parameter int ALUC_W = ctrl_pkg::ALUC_W,
    parameter int DATA_W = ctrl_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ALUC_W-1:0] cmd_alu,
    input  logic [REG_AW-1:0] cmd_rs,
    input  logic [REG_AW-1:0] cmd_rt,
    input  logic [DATA_W-1:0] dp_dout,
    output logic [REG_AW-1:0] r1,
    output logic [REG_AW-1:0] r2,
    output logic [ALUC_W-1:0] aluc,
    output logic              regw,
    output logic              memw,
    output logic              memr,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);
    import ctrl_pkg::*;

    state_e            state;
    state_e            state_nxt;
    op_e               op_q;
    op_e               cmd_op_e;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic [ALUC_W-1:0] alu_q;
    logic              nop_pend;
    logic              done_q;
    logic [DATA_W-1:0] result_q;
    logic              accept;

    assign cmd_op_e  = op_e'(cmd_op);
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid & cmd_ready;

    // State register; reset drops straight to IDLE, which kills the strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state: NOP never leaves IDLE; STORE finishes after MEM, LOAD goes
    // on to WB, ALU skips MEM. Unknown codes recover to IDLE.
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: if (accept && cmd_op_e != OP_NOP) state_nxt = ST_READ;
            ST_READ: state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = (op_q == OP_ALU) ? ST_WB : ST_MEM;
            ST_MEM:  state_nxt = (op_q == OP_LOAD) ? ST_WB : ST_IDLE;
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Command latch. A NOP never drives the address/ALU outputs, so it leaves
    // them untouched and r1/r2/aluc keep showing the last real command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= OP_ALU;
            rs_q  <= '0;
            rt_q  <= '0;
            alu_q <= '0;
        end else if (accept) begin
            op_q <= cmd_op_e;
            if (cmd_op_e != OP_NOP) begin
                rs_q  <= cmd_rs;
                rt_q  <= cmd_rt;
                alu_q <= cmd_alu;
            end
        end
    end

    // Completion and capture: done follows the final state by one cycle (a
    // NOP waits one cycle via nop_pend); dp_dout is captured leaving EXEC for
    // ALU and leaving MEM for LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nop_pend <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            nop_pend <= accept && (cmd_op_e == OP_NOP);
            done_q   <= nop_pend || (state == ST_WB) ||
                        (state == ST_MEM && op_q == OP_STORE);
            if ((state == ST_EXEC && op_q == OP_ALU) ||
                (state == ST_MEM && op_q == OP_LOAD))
                result_q <= dp_dout;
        end
    end

    ctrl_out_decode u_decode (
        .state (state),
        .op    (op_q),
        .regw  (regw),
        .memw  (memw),
        .memr  (memr)
    );

    assign r1     = rs_q;
    assign r2     = rt_q;
    assign aluc   = alu_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_datapath_ctrl_seq.sv
// Self-checking bench for datapath_ctrl_seq: random and directed commands,
// a timing/result model built from the command latencies, and a negedge
// monitor that pops expected completions from a queue.
module tb_datapath_ctrl_seq;

    localparam int AW = 5;
    localparam int CW = 5;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [CW-1:0] cmd_alu = '0;
    logic [AW-1:0] cmd_rs = '0;
    logic [AW-1:0] cmd_rt = '0;
    logic [DW-1:0] dp_dout;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic [CW-1:0] aluc;
    logic          regw;
    logic          memw;
    logic          memr;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; cycle k is the interval after edge k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // dp_dout is a known function of the cycle number, with one optional
    // overridden cycle for directed values.
    int            force_cyc = -1;
    logic [31:0]   force_val = '0;

    function automatic logic [31:0] mix(input int c);
        return (32'(c) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    assign dp_dout = (cyc == force_cyc) ? force_val : mix(cyc);

    datapath_ctrl_seq dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_alu   (cmd_alu),
        .cmd_rs    (cmd_rs),
        .cmd_rt    (cmd_rt),
        .dp_dout   (dp_dout),
        .r1        (r1),
        .r2        (r2),
        .aluc      (aluc),
        .regw      (regw),
        .memw      (memw),
        .memr      (memr),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    // ---------------- reference model ----------------
    // Command with accept edge A is busy in cycles A..A+len-1 and signals
    // done in cycle A+lat.
    int          n_checks = 0;
    int          n_err = 0;
    int          free_at = 0;
    logic [1:0]  act_op = 2'b00;
    logic [4:0]  act_alu = '0, act_rs = '0, act_rt = '0;
    int          act_a = -1000;
    logic [4:0]  prev_alu = '0, prev_rs = '0, prev_rt = '0;
    logic [31:0] model_res = '0;
    logic [63:0] exp_q[$];          // {done cycle, expected result}

    function automatic int op_len(input logic [1:0] op);
        case (op)
            2'b00:   return 3;
            2'b01:   return 4;
            2'b10:   return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int op_lat(input logic [1:0] op);
        return (op == 2'b11) ? 1 : op_len(op);
    endfunction

    function automatic logic [31:0] dp_at(input int c);
        return (c == force_cyc) ? force_val : mix(c);
    endfunction

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic void model_accept(input logic [1:0] op, input logic [4:0] alu,
                                         input logic [4:0] rs, input logic [4:0] rt);
        int a;
        a = cyc + 1;
        if (op == 2'b00) model_res = dp_at(a + 1);
        if (op == 2'b01) model_res = dp_at(a + 2);
        exp_q.push_back({32'(a + op_lat(op)), model_res});
        free_at = a + op_len(op);
        if (op != 2'b11) begin
            prev_alu = act_alu; prev_rs = act_rs; prev_rt = act_rt;
            act_op = op; act_alu = alu; act_rs = rs; act_rt = rt; act_a = a;
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        act_op = 2'b00; act_alu = '0; act_rs = '0; act_rt = '0; act_a = -1000;
        prev_alu = '0; prev_rs = '0; prev_rt = '0;
        model_res = '0;
        free_at = 0;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : mon
        int          off;
        logic        eb;
        logic [63:0] head;
        if (!reset) begin
            off = cyc - act_a;
            eb  = (off >= 0) && (off < op_len(act_op));
            check("busy", busy, eb);
            check("cmd_ready", cmd_ready, !eb);
            check("regw", regw, eb && act_op != 2'b10 && off == op_len(act_op) - 1);
            check("memr", memr, eb && act_op == 2'b01 && off == 2);
            check("memw", memw, eb && act_op == 2'b10 && off == 2);
            check("r1", r1, (off < 0) ? prev_rs : act_rs);
            check("r2", r2, (off < 0) ? prev_rt : act_rt);
            check("aluc", aluc, (off < 0) ? prev_alu : act_alu);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("done_spurious", done, 1'b0);
                end else begin
                    head = exp_q.pop_front();
                    check("done_cycle", cyc, head[63:32]);
                    check("result", result, head[31:0]);
                end
            end else if (exp_q.size() > 0 && int'(exp_q[0][63:32]) <= cyc) begin
                check("done_missing", done, 1'b1);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [1:0] op, input logic [4:0] alu,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input bit noise, input bit use_force,
                         input logic [31:0] fval);
        int guard;
        guard = 0;
        // While the sequencer is busy, optionally wave junk commands at it.
        while (cyc < free_at && guard < 100) begin
            cmd_valid = noise;
            cmd_op  = 2'($urandom_range(0, 3));
            cmd_alu = 5'($urandom);
            cmd_rs  = 5'($urandom);
            cmd_rt  = 5'($urandom);
            @(posedge clk); #1;
            guard++;
        end
        if (use_force) begin
            force_cyc = (op == 2'b01) ? cyc + 3 : cyc + 2;
            force_val = fval;
        end
        cmd_valid = 1'b1;
        cmd_op = op; cmd_alu = alu; cmd_rs = rs; cmd_rt = rt;
        model_accept(op, alu, rs, rt);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op  = 2'($urandom_range(0, 3));
        cmd_alu = 5'($urandom);
        cmd_rs  = 5'($urandom);
        cmd_rt  = 5'($urandom);
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check("wait_done_timeout", exp_q.size(), 0);
    endtask

    task automatic reset_checks();
        check("rst_r1", r1, 0);
        check("rst_r2", r2, 0);
        check("rst_aluc", aluc, 0);
        check("rst_regw", regw, 0);
        check("rst_memw", memw, 0);
        check("rst_memr", memr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_cmd_ready", cmd_ready, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int guard;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        model_reset();
        #2 reset = 1'b0;
        @(posedge clk); #1;

        // ALU: alu=2, rs=0, rt=1, dp_dout=7 during EXEC.
        issue(2'b00, 5'd2, 5'd0, 5'd1, 1'b0, 1'b1, 32'd7);
        wait_done();
        check("alu_result_7", result, 32'd7);

        // LOAD then STORE back-to-back.
        issue(2'b01, 5'd9, 5'd3, 5'd4, 1'b0, 1'b1, 32'hDEADBEEF);
        issue(2'b10, 5'd6, 5'd5, 5'd6, 1'b0, 1'b0, 32'd0);
        wait_done();
        check("store_keeps_result", result, 32'hDEADBEEF);

        // Busy ignore: junk held on cmd_valid while an ALU runs.
        issue(2'b00, 5'd17, 5'd10, 5'd11, 1'b1, 1'b0, 32'd0);
        issue(2'b11, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'd0);
        issue(2'b11, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 32'd0);
        wait_done();

        // Randomized commands with random gaps and busy-time noise.
        for (int i = 0; i < 150; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                cmd_valid = 1'b0;
                @(posedge clk); #1;
            end
            issue(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom),
                  1'($urandom_range(0, 1)), 1'b0, 32'd0);
        end
        wait_done();

        // Reset in the middle of a LOAD while memr is high.
        issue(2'b01, 5'd3, 5'd12, 5'd13, 1'b0, 1'b0, 32'd0);
        guard = 0;
        while (cyc < act_a + 2 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        #2;
        check("pre_reset_memr", memr, 1);
        reset = 1'b1;
        #1;
        reset_checks();
        model_reset();
        #4 reset = 1'b0;
        issue(2'b00, 5'd4, 5'd7, 5'd8, 1'b0, 1'b0, 32'd0);
        issue(2'b01, 5'd5, 5'd9, 5'd2, 1'b0, 1'b0, 32'd0);
        wait_done();

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "time limit");
    end

endmodule
